// File: rtl/predicate_pkg.sv
// Shared widths and the buffered predicate-write record used by the writeback unit.
package predicate_pkg;

    localparam int NUM_LANES = 8;
    localparam int NUM_REGS  = 32;
    localparam int NUM_WARPS = 16;
    localparam int AW        = $clog2(NUM_REGS);
    localparam int WW        = $clog2(NUM_WARPS);

    typedef struct packed {
        logic [WW-1:0]        warp;
        logic [AW-1:0]        addr;
        logic [NUM_LANES-1:0] mask;
        logic [NUM_LANES-1:0] data;
    } pred_wr_t;

    localparam int ENTRY_W = $bits(pred_wr_t);

    function automatic logic entry_matches(input pred_wr_t e, input logic [WW-1:0] warp,
                                           input logic [AW-1:0] addr);
        return (e.warp == warp) && (e.addr == addr);
    endfunction

endpackage

// File: rtl/pred_wb_fifo.sv
// Register FIFO of pending predicate writes; exposes the head plus every slot and its
// occupancy so the top level can answer hazard queries against all queued writes.
module pred_wb_fifo
    import predicate_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [ENTRY_W-1:0]       wr_entry,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [ENTRY_W-1:0]       head,
    output logic [DEPTH*ENTRY_W-1:0] entries,
    output logic [DEPTH-1:0]         entry_valid
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [PW:0]        count;
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic               do_push;
    logic               do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_entry;
    end

    always_comb begin
        entries     = '0;
        entry_valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entries[i*ENTRY_W +: ENTRY_W] = mem[i];
            entry_valid[i] = {1'b0, PW'(PW'(i) - rd_ptr)} < count;
        end
    end

endmodule

// File: rtl/predicate_writeback_unit.sv
// Buffers predicate results and drives the register block write port, sharing its
// warp selector with the read stage and forcing the reader to yield after a bounded wait.
module predicate_writeback_unit
    import predicate_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int MAX_STALL = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WW-1:0]        in_warp,
    input  logic [AW-1:0]        in_addr,
    input  logic [NUM_LANES-1:0] in_mask,
    input  logic [NUM_LANES-1:0] in_data,
    input  logic                 rd_req,
    input  logic [WW-1:0]        rd_warp,
    output logic                 rd_stall,
    output logic [NUM_LANES-1:0] prf_write_en,
    output logic [AW-1:0]        prf_waddr,
    output logic [NUM_LANES-1:0] prf_wdata,
    output logic [WW-1:0]        prf_warp_sel,
    input  logic [WW-1:0]        q_warp,
    input  logic [AW-1:0]        q_addr,
    output logic                 q_pending
);

    localparam int SW = $clog2(MAX_STALL + 1);

    pred_wr_t                 in_entry;
    pred_wr_t                 head;
    logic [ENTRY_W-1:0]       head_bits;
    logic [DEPTH*ENTRY_W-1:0] entries_bits;
    logic [DEPTH-1:0]         entry_valid;
    logic                     full;
    logic                     empty;
    logic                     head_valid;
    logic                     push;
    logic                     grant;
    logic                     force_yield;
    logic [SW-1:0]            stall_cnt;

    assign in_entry = '{warp: in_warp, addr: in_addr, mask: in_mask, data: in_data};
    assign in_ready = !full;
    // Zero-mask results are acknowledged but never occupy a slot.
    assign push     = in_valid && in_ready && (in_mask != '0);

    pred_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .wr_entry    (in_entry),
        .pop         (grant),
        .full        (full),
        .empty       (empty),
        .head        (head_bits),
        .entries     (entries_bits),
        .entry_valid (entry_valid)
    );

    assign head        = pred_wr_t'(head_bits);
    assign head_valid  = !empty;
    assign force_yield = head_valid && (stall_cnt == SW'(MAX_STALL));
    assign rd_stall    = force_yield && rd_req;
    assign grant       = head_valid && (!rd_req || (rd_warp == head.warp) || force_yield);

    always_comb begin
        prf_warp_sel = '0;
        if (rd_req && !force_yield) prf_warp_sel = rd_warp;
        else if (head_valid)        prf_warp_sel = head.warp;
        prf_write_en = grant ? head.mask : '0;
        prf_waddr    = head_valid ? head.addr : '0;
        prf_wdata    = head_valid ? head.data : '0;
    end

    // Counts consecutive cycles the head has been denied the selector.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (!head_valid || grant) begin
            stall_cnt <= '0;
        end else if (stall_cnt != SW'(MAX_STALL)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    always_comb begin
        q_pending = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] &&
                entry_matches(pred_wr_t'(entries_bits[i*ENTRY_W +: ENTRY_W]), q_warp, q_addr))
                q_pending = 1'b1;
        end
    end

endmodule

// File: tb/tb_predicate_writeback_unit.sv
// Directed bench for the predicate writeback unit with a behavioural register-block model.
module tb_predicate_writeback_unit;
    import predicate_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [WW-1:0]        in_warp;
    logic [AW-1:0]        in_addr;
    logic [NUM_LANES-1:0] in_mask;
    logic [NUM_LANES-1:0] in_data;
    logic                 rd_req;
    logic [WW-1:0]        rd_warp;
    logic                 rd_stall;
    logic [NUM_LANES-1:0] prf_write_en;
    logic [AW-1:0]        prf_waddr;
    logic [NUM_LANES-1:0] prf_wdata;
    logic [WW-1:0]        prf_warp_sel;
    logic [WW-1:0]        q_warp;
    logic [AW-1:0]        q_addr;
    logic                 q_pending;

    int checks = 0;
    int errors = 0;

    logic [7:0] rf [16][32];

    predicate_writeback_unit #(.DEPTH(4), .MAX_STALL(7)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_warp(in_warp), .in_addr(in_addr),
        .in_mask(in_mask), .in_data(in_data),
        .rd_req(rd_req), .rd_warp(rd_warp), .rd_stall(rd_stall),
        .prf_write_en(prf_write_en), .prf_waddr(prf_waddr), .prf_wdata(prf_wdata),
        .prf_warp_sel(prf_warp_sel),
        .q_warp(q_warp), .q_addr(q_addr), .q_pending(q_pending)
    );

    always #5 clk = ~clk;

    // Downstream register block: masked per-lane write at the clock edge.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++)
                if (prf_write_en[i]) rf[prf_warp_sel][prf_waddr][i] <= prf_wdata[i];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    task automatic push_entry(input logic [3:0] w, input logic [4:0] a,
                              input logic [7:0] m, input logic [7:0] d);
        in_valid = 1'b1; in_warp = w; in_addr = a; in_mask = m; in_data = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_warp = '0; in_addr = '0; in_mask = '0; in_data = '0;
        rd_req = 1'b0; rd_warp = '0; q_warp = '0; q_addr = '0;
        for (int w = 0; w < 16; w++)
            for (int a = 0; a < 32; a++) rf[w][a] = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({in_ready, rd_stall, q_pending} !== 3'b100) begin
            errors++;
            $display("FAIL reset_ctrl: got ready/stall/pend=%b required 100", {in_ready, rd_stall, q_pending});
        end
        checks++;
        if ({prf_write_en, prf_waddr, prf_wdata, prf_warp_sel} !== '0) begin
            errors++;
            $display("FAIL reset_prf: got we=%h addr=%h data=%h sel=%h required all 0",
                     prf_write_en, prf_waddr, prf_wdata, prf_warp_sel);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_idle_stream();
        int bad = 0;
        logic [3:0] w;
        logic [4:0] a;
        for (int wi = 0; wi < 16; wi++) begin
            for (int ai = 0; ai < 32; ai++) begin
                w = wi[3:0]; a = ai[4:0];
                push_entry(w, a, 8'hFF, 8'hFF);
                @(negedge clk);
                checks++;
                if ({prf_write_en, prf_waddr, prf_warp_sel, prf_wdata} !== {8'hFF, a, w, 8'hFF}) begin
                    errors++;
                    $display("FAIL idle_commit w%0d r%0d: got we=%h addr=%0d sel=%0d data=%h required ff/%0d/%0d/ff",
                             wi, ai, prf_write_en, prf_waddr, prf_warp_sel, prf_wdata, ai, wi);
                end
                @(posedge clk); #1;
            end
        end
        for (int wi = 0; wi < 16; wi++)
            for (int ai = 0; ai < 32; ai++)
                if (rf[wi][ai] !== 8'hFF) bad++;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL idle_readback: got %0d registers not ff required 0", bad);
        end
    endtask

    task automatic test_partial_mask();
        push_entry(4'd2, 5'd3, 8'hFF, 8'h00);
        push_entry(4'd2, 5'd3, 8'h0F, 8'hFF);
        @(posedge clk); #1;
        checks++;
        if (rf[2][3] !== 8'h0F) begin
            errors++;
            $display("FAIL partial_mask: got %h required 0f", rf[2][3]);
        end
    endtask

    task automatic test_contention();
        rd_req = 1'b1; rd_warp = 4'd9;
        push_entry(4'd5, 5'd7, 8'hFF, 8'hA5);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            checks++;
            if ({prf_write_en, rd_stall, prf_warp_sel} !== {8'h00, 1'b0, 4'd9}) begin
                errors++;
                $display("FAIL contention_wait%0d: got we=%h stall=%b sel=%0d required 00/0/9",
                         k, prf_write_en, rd_stall, prf_warp_sel);
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++;
        if ({prf_write_en, rd_stall, prf_warp_sel} !== {8'hFF, 1'b1, 4'd5}) begin
            errors++;
            $display("FAIL contention_force: got we=%h stall=%b sel=%0d required ff/1/5",
                     prf_write_en, rd_stall, prf_warp_sel);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({rf[5][7], rd_stall, prf_warp_sel, prf_write_en} !== {8'hA5, 1'b0, 4'd9, 8'h00}) begin
            errors++;
            $display("FAIL contention_after: got rf=%h stall=%b sel=%0d we=%h required a5/0/9/00",
                     rf[5][7], rd_stall, prf_warp_sel, prf_write_en);
        end
        rd_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_same_warp();
        rd_req = 1'b1; rd_warp = 4'd5;
        push_entry(4'd5, 5'd8, 8'h3C, 8'h14);
        @(negedge clk);
        checks++;
        if ({prf_write_en, rd_stall, prf_warp_sel} !== {8'h3C, 1'b0, 4'd5}) begin
            errors++;
            $display("FAIL same_warp_grant: got we=%h stall=%b sel=%0d required 3c/0/5",
                     prf_write_en, rd_stall, prf_warp_sel);
        end
        @(posedge clk); #1;
        checks++;
        if (rf[5][8] !== 8'hD7) begin
            errors++;
            $display("FAIL same_warp_data: got %h required d7", rf[5][8]);
        end
        rd_req = 1'b0;
    endtask

    task automatic test_full();
        logic [4:0] a;
        rd_req = 1'b1; rd_warp = 4'd9;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_warp = 4'd3; a = 5'(10 + i); in_addr = a;
            in_mask = 8'hFF; in_data = 8'(i);
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL full_fill%0d: got in_ready=%b required 1", i, in_ready);
            end
            @(posedge clk); #1;
        end
        in_addr = 5'd14; in_data = 8'd4;
        @(negedge clk);
        checks++;
        if ({in_ready, prf_write_en} !== {1'b0, 8'h00}) begin
            errors++;
            $display("FAIL full_block: got ready=%b we=%h required 0/00", in_ready, prf_write_en);
        end
        q_warp = 4'd3;
        for (int i = 0; i < 5; i++) begin
            q_addr = 5'(10 + i); #1;
            checks++;
            if (q_pending !== (i < 4)) begin
                errors++;
                $display("FAIL full_pending r%0d: got %b required %b", 10 + i, q_pending, i < 4);
            end
        end
        @(posedge clk); #1;
        rd_req = 1'b0; q_addr = 5'd10;
        @(negedge clk);
        checks++;
        if ({in_ready, prf_write_en, prf_waddr, q_pending} !== {1'b0, 8'hFF, 5'd10, 1'b1}) begin
            errors++;
            $display("FAIL full_pop: got ready=%b we=%h addr=%0d pend=%b required 0/ff/10/1",
                     in_ready, prf_write_en, prf_waddr, q_pending);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({in_ready, prf_waddr, q_pending} !== {1'b1, 5'd11, 1'b0}) begin
            errors++;
            $display("FAIL full_refill: got ready=%b addr=%0d pend=%b required 1/11/0",
                     in_ready, prf_waddr, q_pending);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 12; i <= 14; i++) begin
            @(negedge clk);
            checks++;
            if ({prf_write_en, prf_waddr} !== {8'hFF, 5'(i)}) begin
                errors++;
                $display("FAIL full_drain r%0d: got we=%h addr=%0d", i, prf_write_en, prf_waddr);
            end
            @(posedge clk); #1;
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rf[3][10 + i] !== 8'(i)) begin
                errors++;
                $display("FAIL full_readback r%0d: got %h required %h", 10 + i, rf[3][10 + i], 8'(i));
            end
        end
    endtask

    task automatic test_zero_mask();
        in_valid = 1'b1; in_warp = 4'd6; in_addr = 5'd1; in_mask = 8'h00; in_data = 8'hFF;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_mask_ready: got %b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; q_warp = 4'd6; q_addr = 5'd1;
        @(negedge clk);
        checks++;
        if ({prf_write_en, q_pending} !== {8'h00, 1'b0}) begin
            errors++;
            $display("FAIL zero_mask_drop: got we=%h pend=%b required 00/0", prf_write_en, q_pending);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midflight();
        int stray = 0;
        rd_req = 1'b1; rd_warp = 4'd9;
        for (int i = 0; i < 3; i++) push_entry(4'd7, 5'(i), 8'hFF, 8'h00);
        q_warp = 4'd7; q_addr = 5'd0;
        @(negedge clk);
        checks++;
        if (q_pending !== 1'b1) begin
            errors++;
            $display("FAIL midflight_queued: got pend=%b required 1", q_pending);
        end
        rst = 1'b1; #1;
        checks++;
        if ({in_ready, prf_write_en, q_pending} !== {1'b1, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL midflight_reset: got ready=%b we=%h pend=%b required 1/00/0",
                     in_ready, prf_write_en, q_pending);
        end
        repeat (2) @(posedge clk);
        #1; rst = 1'b0; rd_req = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (prf_write_en !== 8'h00) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL midflight_stale: got %0d write cycles required 0", stray);
        end
        checks++;
        if ({rf[7][0], rf[7][1], rf[7][2]} !== 24'hFFFFFF) begin
            errors++;
            $display("FAIL midflight_rf: got %h %h %h required ff ff ff", rf[7][0], rf[7][1], rf[7][2]);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_idle_stream();
        test_partial_mask();
        test_contention();
        test_same_warp();
        test_full();
        test_zero_mask();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
